// File: rtl/debounce_array_pkg.sv
// Shared helpers for the debounce_array slice.
// Counter widths are sized so that a range of 0..x-1 always fits, with a floor of one bit.
package debounce_array_pkg;

    function automatic int unsigned cnt_width(input int unsigned x);
        return (x <= 2) ? 1 : $clog2(x);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One debounced bit: synchroniser chain, stability counter and registered out/rise/fall.
// State only advances in cycles where the shared sample tick is high.
module debounce_channel
    import debounce_array_pkg::*;
#(
    parameter int unsigned STABLE      = 4,
    parameter int unsigned SYNC_STAGES = 2,
    parameter logic        INIT        = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic tick,
    input  logic in,
    output logic out,
    output logic rise,
    output logic fall
);

    localparam int unsigned SW = cnt_width(STABLE);
    localparam logic [SW-1:0] STAB_MAX = SW'(STABLE - 1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   sync;
    logic [SW-1:0]          stab_q, stab_d;
    logic                   out_q, out_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;

    assign sync = sync_q[SYNC_STAGES-1];

    always_comb begin
        stab_d = stab_q;
        out_d  = out_q;
        rise_d = 1'b0;
        fall_d = 1'b0;
        if (tick) begin
            if (sync == out_q) begin
                // Any agreeing sample throws away partial progress toward a change.
                stab_d = '0;
            end else if (stab_q == STAB_MAX) begin
                stab_d = '0;
                out_d  = sync;
                rise_d = sync;
                fall_d = ~sync;
            end else begin
                stab_d = stab_q + SW'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= {SYNC_STAGES{INIT}};
            stab_q <= '0;
            out_q  <= INIT;
            rise_q <= 1'b0;
            fall_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], in};
            stab_q <= stab_d;
            out_q  <= out_d;
            rise_q <= rise_d;
            fall_q <= fall_d;
        end
    end

    assign out  = out_q;
    assign rise = rise_q;
    assign fall = fall_q;

endmodule

// File: rtl/debounce_array.sv
// Multi-channel debouncer for slow asynchronous pad inputs.
// A single prescaler produces the sample tick shared by every channel.
module debounce_array
    import debounce_array_pkg::*;
#(
    parameter int unsigned          CHANNELS    = 4,
    parameter int unsigned          DIV         = 20,
    parameter int unsigned          STABLE      = 4,
    parameter int unsigned          SYNC_STAGES = 2,
    parameter logic [CHANNELS-1:0]  INIT        = '0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [CHANNELS-1:0] in,
    output logic [CHANNELS-1:0] out,
    output logic [CHANNELS-1:0] rise,
    output logic [CHANNELS-1:0] fall,
    output logic                tick
);

    localparam int unsigned   CW      = cnt_width(DIV);
    localparam logic [CW-1:0] CNT_MAX = CW'(DIV - 1);

    if (DIV < 1) begin : g_bad_div
        $error("debounce_array: DIV must be >= 1");
    end
    if (STABLE < 1) begin : g_bad_stable
        $error("debounce_array: STABLE must be >= 1");
    end
    if (SYNC_STAGES < 2) begin : g_bad_sync
        $error("debounce_array: SYNC_STAGES must be >= 2");
    end

    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick_q, tick_d;

    always_comb begin
        tick_d = (cnt_q == CNT_MAX);
        cnt_d  = tick_d ? '0 : cnt_q + CW'(1);
    end

    // Tick is registered, so the first one lands DIV cycles after reset release.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

    for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
        debounce_channel #(
            .STABLE      (STABLE),
            .SYNC_STAGES (SYNC_STAGES),
            .INIT        (INIT[i])
        ) u_ch (
            .clk  (clk),
            .rst  (rst),
            .tick (tick_q),
            .in   (in[i]),
            .out  (out[i]),
            .rise (rise[i]),
            .fall (fall[i])
        );
    end

endmodule
